aes_encrypt_core: RTL and testbench

- Iterative AES block cipher, encrypt direction only, per FIPS-197.
- Computes one round per clock and expands the key schedule on the fly.
- Parameterised for AES-128, AES-192 and AES-256.
- Sits beside a matching decrypt core. Both share the load strobe and key bus, and the decrypt core consumes this block's ct output.

---
 rtl/aes_pkg.sv | 105 ++++++++++
 rtl/aes_enc_round.sv | 56 +++++
 rtl/aes_encrypt_core.sv | 146 ++++++++++++++
 tb/tb_aes_encrypt_core.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES helpers for the encrypt and decrypt cores.
//   - word_t / block_t    : 32-bit column word and 128-bit block types
//   - state_e             : round controller states
//   - sbox()              : forward S-box lookup
//   - xtime() / gmul()    : GF(2^8) arithmetic, modulus 0x11B
//   - rcon()              : round constant for a key-schedule word group
//   - sub_word/rot_word   : key schedule word transforms
//   - nr_of()             : number of rounds for a given Nk
//   - byte_idx/get_byte   : column/row to byte position helpers
// Byte n of a block lives at bits [8n+7:8n]; column c is bits [32c+31:32c].
// ---------------------------------------------------------------------------
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  // Entry 0 sits in the most significant byte, so entry a is found at
  // bit 2047 - 8a, which is {~a, 3'b111}.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX_TABLE[{~a, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  // Rcon[1..10]; indices past the table only occur for words that are
  // never used as a round key, so they return zero.
  function automatic logic [7:0] rcon(input int i);
    case (i)
      1:       return 8'h01;
      2:       return 8'h02;
      3:       return 8'h04;
      4:       return 8'h08;
      5:       return 8'h10;
      6:       return 8'h20;
      7:       return 8'h40;
      8:       return 8'h80;
      9:       return 8'h1b;
      10:      return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic word_t sub_word(input word_t w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte 0 is the LSB, so rotating [a0,a1,a2,a3] -> [a1,a2,a3,a0] is a
  // right rotate by one byte.
  function automatic word_t rot_word(input word_t w);
    return {w[7:0], w[31:8]};
  endfunction

  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction

  function automatic int byte_idx(input int c, input int r);
    return 4 * c + r;
  endfunction

  function automatic logic [7:0] get_byte(input block_t b, input int n);
    return b[8 * n +: 8];
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// ---------------------------------------------------------------------------
// aes_enc_round
// One combinational AES encryption round.
//   state_in     : block entering the round
//   round_key    : round key, word 0 in bits [31:0]
//   final_round  : 1 skips MixColumns (last round)
//   state_out    : AddRoundKey(MixColumns?(ShiftRows(SubBytes(state_in))))
// ---------------------------------------------------------------------------
module aes_enc_round
  import aes_pkg::*;
(
  input  block_t state_in,
  input  block_t round_key,
  input  logic   final_round,
  output block_t state_out
);

  block_t sub_shift;
  block_t mixed;

  function automatic word_t mix_column(input word_t col);
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] a3;
    a0 = col[7:0];
    a1 = col[15:8];
    a2 = col[23:16];
    a3 = col[31:24];
    return {xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3),
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3};
  endfunction

  // Row r of output column c comes from input column (c + r) mod 4.
  always_comb begin
    sub_shift = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sub_shift[8 * byte_idx(c, r) +: 8] =
          sbox(get_byte(state_in, byte_idx((c + r) % 4, r)));
      end
    end
  end

  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[32 * c +: 32] = mix_column(sub_shift[32 * c +: 32]);
    end
  end

  assign state_out = (final_round ? sub_shift : mixed) ^ round_key;

endmodule

// File: rtl/aes_encrypt_core.sv
// ---------------------------------------------------------------------------
// aes_encrypt_core
// Iterative AES encryption, one round per clock, key schedule expanded on
// the fly. Nk = 4/6/8 selects AES-128/192/256.
//   clk, rst_b : clock, asynchronous active-low reset
//   load       : start strobe, captures key and pt (restarts if busy)
//   key        : cipher key, word j at [32j+31:32j]
//   pt         : plaintext block
//   ct_valid   : ct holds the result of the most recent load
//   ct         : ciphertext register, written only on the final round
// ---------------------------------------------------------------------------
module aes_encrypt_core
  import aes_pkg::*;
#(
  parameter int Nk = 4
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              load,
  input  logic [32*Nk-1:0]  key,
  input  block_t            pt,
  output logic              ct_valid,
  output block_t            ct
);

  localparam int         NR         = nr_of(Nk);
  localparam logic [3:0] LAST_ROUND = 4'(NR);

  generate
    if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_nk
      $error("aes_encrypt_core: Nk must be 4, 6 or 8");
    end
  endgenerate

  state_e     state_q, state_d;
  logic [3:0] round_q, round_d;
  block_t     blk_q, blk_d;
  block_t     ct_d;
  logic       ct_valid_d;
  word_t      win_q    [Nk];
  word_t      win_d    [Nk];
  word_t      win_src  [Nk];
  word_t      win_next [Nk];
  logic [3:0] base_round;
  block_t     round_key;
  block_t     round_out;

  // The window holds w[4r .. 4r+Nk-1] while round r is pending, so its
  // first four words are always the round key about to be used. A load
  // restarts the window from the raw key with r = 0.
  always_comb begin
    for (int j = 0; j < Nk; j++) begin
      win_src[j] = load ? key[32 * j +: 32] : win_q[j];
    end
    base_round = load ? 4'd0 : round_q;
  end

  // Slide the window by four words: new word i = 4r+Nk+k is
  // w[i-Nk] ^ temp, with temp derived from the word just before it.
  always_comb begin : p_advance
    word_t prev;
    word_t temp;
    int    idx;
    for (int j = 0; j < Nk - 4; j++) begin
      win_next[j] = win_src[j + 4];
    end
    prev = win_src[Nk-1];
    for (int k = 0; k < 4; k++) begin
      idx = 4 * int'(base_round) + Nk + k;
      if (idx % Nk == 0) begin
        temp = sub_word(rot_word(prev)) ^ {24'h000000, rcon(idx / Nk)};
      end else if (Nk == 8 && idx % Nk == 4) begin
        temp = sub_word(prev);
      end else begin
        temp = prev;
      end
      win_next[Nk-4+k] = win_src[k] ^ temp;
      prev = win_next[Nk-4+k];
    end
  end

  assign round_key = {win_q[3], win_q[2], win_q[1], win_q[0]};

  aes_enc_round u_round (
    .state_in    (blk_q),
    .round_key   (round_key),
    .final_round (round_q == LAST_ROUND),
    .state_out   (round_out)
  );

  // Load always wins, so a strobe while busy (or held high) restarts.
  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    blk_d      = blk_q;
    ct_d       = ct;
    ct_valid_d = ct_valid;
    for (int j = 0; j < Nk; j++) begin
      win_d[j] = win_q[j];
    end
    if (load) begin
      state_d    = ST_BUSY;
      round_d    = 4'd1;
      blk_d      = pt ^ key[127:0];
      ct_valid_d = 1'b0;
      for (int j = 0; j < Nk; j++) begin
        win_d[j] = win_next[j];
      end
    end else if (state_q == ST_BUSY) begin
      blk_d   = round_out;
      round_d = round_q + 4'd1;
      for (int j = 0; j < Nk; j++) begin
        win_d[j] = win_next[j];
      end
      if (round_q == LAST_ROUND) begin
        ct_d       = round_out;
        ct_valid_d = 1'b1;
        state_d    = ST_IDLE;
        round_d    = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= ST_IDLE;
      round_q  <= 4'd0;
      blk_q    <= '0;
      ct       <= '0;
      ct_valid <= 1'b0;
      for (int j = 0; j < Nk; j++) begin
        win_q[j] <= '0;
      end
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      blk_q    <= blk_d;
      ct       <= ct_d;
      ct_valid <= ct_valid_d;
      for (int j = 0; j < Nk; j++) begin
        win_q[j] <= win_d[j];
      end
    end
  end

endmodule

// File: tb/tb_aes_encrypt_core.sv
// ---------------------------------------------------------------------------
// tb_aes_encrypt_core
// Drives AES-128/192/256 instances of aes_encrypt_core with FIPS-197
// known answers, reload/abort/held-load/async-reset cases and random
// vectors checked against a byte-oriented reference model.
// ---------------------------------------------------------------------------
module tb_aes_encrypt_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_b;
  logic         load4, load6, load8;
  logic [127:0] key4;
  logic [191:0] key6;
  logic [255:0] key8;
  logic [127:0] pt4, pt6, pt8;
  logic [127:0] ct4, ct6, ct8;
  logic         v4, v6, v8;

  aes_encrypt_core #(.Nk(4)) u_dut4 (
    .clk(clk), .rst_b(rst_b), .load(load4), .key(key4), .pt(pt4),
    .ct_valid(v4), .ct(ct4));
  aes_encrypt_core #(.Nk(6)) u_dut6 (
    .clk(clk), .rst_b(rst_b), .load(load6), .key(key6), .pt(pt6),
    .ct_valid(v6), .ct(ct6));
  aes_encrypt_core #(.Nk(8)) u_dut8 (
    .clk(clk), .rst_b(rst_b), .load(load8), .key(key8), .pt(pt8),
    .ct_valid(v8), .ct(ct8));

  localparam logic [127:0] PT_KAT  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [255:0] KEY_KAT =
    256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] CT_128  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
  localparam logic [127:0] CT_192  = 128'h91710deca070af6ee0df4c86a47ca9dd;
  localparam logic [127:0] CT_256  = 128'h8960494b9049fceabf456751cab7a28e;

  int           n_cmp  = 0;
  int           n_fail = 0;
  logic [7:0]   sbox_ref [256];
  logic [127:0] exp_q [$];

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul_ref(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    logic       hi;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      hi = x[7];
      x  = x << 1;
      if (hi) x = x ^ 8'h1b;
      y  = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x);
    return {x[6:0], x[7]};
  endfunction

  // S-box rebuilt from its definition: GF inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] r;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gmul_ref(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      r = inv;
      sbox_ref[a] = inv ^ 8'h63;
      for (int s = 0; s < 4; s++) begin
        r = rotl8(r);
        sbox_ref[a] = sbox_ref[a] ^ r;
      end
    end
  endtask

  function automatic logic [31:0] sub_word_ref(input logic [31:0] w);
    return {sbox_ref[w[31:24]], sbox_ref[w[23:16]], sbox_ref[w[15:8]], sbox_ref[w[7:0]]};
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [255:0] k, input int nk,
                                               input logic [127:0] p);
    logic [31:0]  w [60];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] res;
    int           nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = k[32*i +: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = sub_word_ref({tmp[7:0], tmp[31:8]}) ^ {24'h0, rc};
        rc  = gmul_ref(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        tmp = sub_word_ref(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int n = 0; n < 16; n++) s[n] = p[8*n +: 8] ^ w[n/4][8*(n%4) +: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int n = 0; n < 16; n++) t[n] = sbox_ref[s[n]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[row + 4*c] = t[row + 4*((c + row) % 4)];
      if (r != nr) begin
        for (int c = 0; c < 4; c++) begin
          t[0] = s[4*c]; t[1] = s[4*c+1]; t[2] = s[4*c+2]; t[3] = s[4*c+3];
          s[4*c]   = gmul_ref(t[0], 8'h02) ^ gmul_ref(t[1], 8'h03) ^ t[2] ^ t[3];
          s[4*c+1] = t[0] ^ gmul_ref(t[1], 8'h02) ^ gmul_ref(t[2], 8'h03) ^ t[3];
          s[4*c+2] = t[0] ^ t[1] ^ gmul_ref(t[2], 8'h02) ^ gmul_ref(t[3], 8'h03);
          s[4*c+3] = gmul_ref(t[0], 8'h03) ^ t[1] ^ t[2] ^ gmul_ref(t[3], 8'h02);
        end
      end
      for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[4*r + n/4][8*(n%4) +: 8];
    end
    for (int n = 0; n < 16; n++) res[8*n +: 8] = s[n];
    return res;
  endfunction

  // ---------------- helpers ----------------
  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [255:0] rand256();
    return {rand128(), rand128()};
  endfunction

  function automatic logic [127:0] ct_of(input int nk);
    return (nk == 4) ? ct4 : (nk == 6) ? ct6 : ct8;
  endfunction

  function automatic logic valid_of(input int nk);
    return (nk == 4) ? v4 : (nk == 6) ? v6 : v8;
  endfunction

  task automatic check_output(input string tag, input logic [127:0] obs,
                              input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic set_inputs(input int nk, input logic ld, input logic [255:0] k,
                            input logic [127:0] p);
    case (nk)
      4:       begin load4 = ld; key4 = k[127:0]; pt4 = p; end
      6:       begin load6 = ld; key6 = k[191:0]; pt6 = p; end
      default: begin load8 = ld; key8 = k;        pt8 = p; end
    endcase
  endtask

  // Pulse load for one edge, scramble key/pt right after the edge, then
  // wait (bounded) for ct_valid and score latency and ciphertext.
  task automatic apply_stimulus(input int nk, input logic [255:0] k,
                                input logic [127:0] p, input logic [127:0] exp_ct,
                                input string tag, input bit hold_check,
                                input logic [127:0] hold_val);
    int cyc;
    bit done;
    @(negedge clk);
    set_inputs(nk, 1'b1, k, p);
    exp_q.push_back(exp_ct);
    @(posedge clk);
    #1;
    set_inputs(nk, 1'b0, rand256(), rand128());
    if (hold_check) begin
      check_output({tag, " valid_drop"}, {127'b0, valid_of(nk)}, 128'd0);
      check_output({tag, " ct_hold"}, ct_of(nk), hold_val);
    end
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (valid_of(nk)) done = 1'b1;
      else if (hold_check) check_output({tag, " ct_hold"}, ct_of(nk), hold_val);
    end
    check_output({tag, " latency"}, 128'(cyc), 128'(nk + 6));
    check_output({tag, " ct"}, ct_of(nk), exp_q.pop_front());
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [255:0] k;
    logic [127:0] p;

    rst_b = 1'b0;
    set_inputs(4, 1'b0, '0, '0);
    set_inputs(6, 1'b0, '0, '0);
    set_inputs(8, 1'b0, '0, '0);
    build_sbox();

    repeat (4) @(posedge clk);
    #1;
    check_output("reset v4",  {127'b0, v4}, 128'd0);
    check_output("reset ct4", ct4, 128'd0);
    check_output("reset v6",  {127'b0, v6}, 128'd0);
    check_output("reset ct6", ct6, 128'd0);
    check_output("reset v8",  {127'b0, v8}, 128'd0);
    check_output("reset ct8", ct8, 128'd0);
    @(negedge clk);
    rst_b = 1'b1;

    apply_stimulus(4, KEY_KAT, PT_KAT, CT_128, "kat128", 1'b0, '0);
    apply_stimulus(4, KEY_KAT, PT_KAT, CT_128, "reload128", 1'b1, CT_128);
    apply_stimulus(6, KEY_KAT, PT_KAT, CT_192, "kat192", 1'b0, '0);
    apply_stimulus(8, KEY_KAT, PT_KAT, CT_256, "kat256", 1'b0, '0);

    // Abort: start one block, then reload with different inputs mid-way.
    @(negedge clk);
    set_inputs(4, 1'b1, rand256(), rand128());
    @(negedge clk);
    set_inputs(4, 1'b0, rand256(), rand128());
    repeat (4) @(negedge clk);
    k = rand256();
    p = rand128();
    apply_stimulus(4, k, p, ref_encrypt(k, 4, p), "abort128", 1'b0, '0);

    // Load held high: every edge restarts and ct_valid stays low.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_inputs(4, 1'b1, rand256(), rand128());
      @(posedge clk);
      #1;
      check_output("held valid", {127'b0, v4}, 128'd0);
    end
    k = rand256();
    p = rand128();
    apply_stimulus(4, k, p, ref_encrypt(k, 4, p), "held128", 1'b0, '0);

    // Asynchronous reset in the middle of a block, sampled between edges.
    @(negedge clk);
    set_inputs(8, 1'b1, rand256(), rand128());
    @(negedge clk);
    set_inputs(8, 1'b0, rand256(), rand128());
    repeat (3) @(negedge clk);
    #2;
    rst_b = 1'b0;
    #1;
    check_output("async v4",  {127'b0, v4}, 128'd0);
    check_output("async ct4", ct4, 128'd0);
    check_output("async ct8", ct8, 128'd0);
    @(negedge clk);
    rst_b = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check_output("post reset idle v8", {127'b0, v8}, 128'd0);

    // Random vectors, key bus scrambled right after each load edge.
    for (int nk = 4; nk <= 8; nk += 2) begin
      for (int i = 0; i < 6; i++) begin
        k = rand256();
        p = rand128();
        apply_stimulus(nk, k, p, ref_encrypt(k, nk, p), $sformatf("rand nk%0d #%0d", nk, i),
                       1'b0, '0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
